// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch: samples PC on start, checks alignment/range, runs one
// valid/ready read to instruction memory and reports done, or a fault with a cause code.
module instr_fetch #(
    parameter logic [31:0] INIT       = 32'h0000_3000,
    parameter logic [31:0] TEXT_BYTES = 32'h0000_1000,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        done,
    output logic        pc_write,
    output logic [31:0] pc_plus4,
    output logic [31:0] ir,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data
);

    localparam int unsigned     CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] FC_MISALIGNED = 2'b01;
    localparam logic [1:0] FC_RANGE      = 2'b10;
    localparam logic [1:0] FC_TIMEOUT    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic [31:0]      pc_plus4_q;
    logic [31:0]      ir_q;
    logic [1:0]       fault_code_q;
    logic             busy_q;
    logic             done_q;
    logic             pc_write_q;
    logic             fault_q;
    logic             mem_req_valid_q;

    // Address checks on the incoming PC, used only in the cycle start is accepted
    logic [31:0] offset_c;
    logic        misaligned_c;
    logic        out_of_range_c;
    logic        cnt_expired_c;
    logic [31:0] pc_plus4_d;

    assign offset_c       = pc - INIT;
    assign misaligned_c   = (pc[1:0] != 2'b00);
    assign out_of_range_c = (pc < INIT) || (offset_c >= TEXT_BYTES);
    assign cnt_expired_c  = (cnt_q == CNT_LAST);
    assign pc_plus4_d     = pc + 32'd4;

    // Fetch sequencer; all outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            addr_q          <= INIT;
            pc_plus4_q      <= INIT;
            ir_q            <= '0;
            fault_code_q    <= 2'b00;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pc_write_q      <= 1'b0;
            fault_q         <= 1'b0;
            mem_req_valid_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            pc_write_q <= 1'b0;
            fault_q    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q     <= pc;
                        pc_plus4_q <= pc_plus4_d;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        if (misaligned_c) begin
                            state_q      <= S_FAULT;
                            fault_q      <= 1'b1;
                            fault_code_q <= FC_MISALIGNED;
                        end else if (out_of_range_c) begin
                            state_q      <= S_FAULT;
                            fault_q      <= 1'b1;
                            fault_code_q <= FC_RANGE;
                        end else begin
                            state_q         <= S_REQ;
                            mem_req_valid_q <= 1'b1;
                        end
                    end
                end

                S_REQ: begin
                    if (mem_req_ready) begin
                        state_q         <= S_WAIT;
                        mem_req_valid_q <= 1'b0;
                    end else if (cnt_expired_c) begin
                        state_q         <= S_FAULT;
                        mem_req_valid_q <= 1'b0;
                        fault_q         <= 1'b1;
                        fault_code_q    <= FC_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        state_q    <= S_DONE;
                        ir_q       <= mem_rsp_data;
                        done_q     <= 1'b1;
                        pc_write_q <= 1'b1;
                    end else if (cnt_expired_c) begin
                        state_q      <= S_FAULT;
                        fault_q      <= 1'b1;
                        fault_code_q <= FC_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_DONE, S_FAULT: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q         <= S_IDLE;
                    busy_q          <= 1'b0;
                    mem_req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pc_write      = pc_write_q;
    assign pc_plus4      = pc_plus4_q;
    assign ir            = ir_q;
    assign fault         = fault_q;
    assign fault_code    = fault_code_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = addr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: each task drives one scenario and checks cycle-exact results.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] pc;
    logic        busy;
    logic        done;
    logic        pc_write;
    logic [31:0] pc_plus4;
    logic [31:0] ir;
    logic        fault;
    logic [1:0]  fault_code;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    int tests = 0;
    int fails = 0;

    instr_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .pc            (pc),
        .busy          (busy),
        .done          (done),
        .pc_write      (pc_write),
        .pc_plus4      (pc_plus4),
        .ir            (ir),
        .fault         (fault),
        .fault_code    (fault_code),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
        $fatal(1, "watchdog");
    end

    // One clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; pc = 32'h0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
        step(); step();
        reset = 1'b0;
        tests++;
        if ({busy, done, pc_write, fault, mem_req_valid} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: busy/done/pc_write/fault/req=%b expected 00000",
                     {busy, done, pc_write, fault, mem_req_valid});
        end
        tests++;
        if (ir !== 32'h0 || fault_code !== 2'b00) begin
            fails++;
            $display("FAIL reset_ir: ir=%h code=%b expected 00000000 00", ir, fault_code);
        end
        tests++;
        if (pc_plus4 !== 32'h3000 || mem_addr !== 32'h3000) begin
            fails++;
            $display("FAIL reset_addr: pc_plus4=%h mem_addr=%h expected 00003000 00003000",
                     pc_plus4, mem_addr);
        end
    endtask

    task automatic test_basic_fetch();
        start = 1'b1; pc = 32'h3000;
        step();
        start = 1'b0;
        tests++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h3000 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_req: req=%b addr=%h busy=%b expected 1 00003000 1",
                     mem_req_valid, mem_addr, busy);
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        tests++;
        if (mem_req_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_wait: req=%b done=%b busy=%b expected 0 0 1",
                     mem_req_valid, done, busy);
        end
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h8C01_0004;
        step();
        mem_rsp_valid = 1'b0;
        tests++;
        if (done !== 1'b1 || pc_write !== 1'b1 || ir !== 32'h8C01_0004 || pc_plus4 !== 32'h3004) begin
            fails++;
            $display("FAIL basic_done: done=%b pc_write=%b ir=%h pc_plus4=%h expected 1 1 8c010004 00003004",
                     done, pc_write, ir, pc_plus4);
        end
        step();
        tests++;
        if (done !== 1'b0 || pc_write !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle: done=%b pc_write=%b busy=%b expected 0 0 0",
                     done, pc_write, busy);
        end
    endtask

    task automatic test_misaligned();
        start = 1'b1; pc = 32'h3002;
        step();
        start = 1'b0;
        tests++;
        if (fault !== 1'b1 || fault_code !== 2'b01 || mem_req_valid !== 1'b0 || pc_write !== 1'b0) begin
            fails++;
            $display("FAIL misaligned_fault: fault=%b code=%b req=%b pc_write=%b expected 1 01 0 0",
                     fault, fault_code, mem_req_valid, pc_write);
        end
        step();
        tests++;
        if (fault !== 1'b0 || busy !== 1'b0 || fault_code !== 2'b01 || ir !== 32'h8C01_0004
            || mem_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL misaligned_after: fault=%b busy=%b code=%b ir=%h req=%b expected 0 0 01 8c010004 0",
                     fault, busy, fault_code, ir, mem_req_valid);
        end
    endtask

    task automatic test_range();
        logic [31:0] bad_pc [3];
        int done_cyc;
        bad_pc[0] = 32'h2FFC; bad_pc[1] = 32'h4000; bad_pc[2] = 32'hFFFF_FFFC;
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; pc = bad_pc[i];
            step();
            start = 1'b0;
            tests++;
            if (fault !== 1'b1 || fault_code !== 2'b10 || mem_req_valid !== 1'b0) begin
                fails++;
                $display("FAIL range_fault[%0d]: pc=%h fault=%b code=%b req=%b expected 1 10 0",
                         i, bad_pc[i], fault, fault_code, mem_req_valid);
            end
            step();
        end
        tests++;
        if (pc_plus4 !== 32'h0 || ir !== 32'h8C01_0004) begin
            fails++;
            $display("FAIL range_wrap: pc_plus4=%h ir=%h expected 00000000 8c010004", pc_plus4, ir);
        end
        // Last legal word: ready and response held high fetch at minimum latency
        done_cyc = -1;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
        start = 1'b1; pc = 32'h3FFC;
        step();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
            step();
        end
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        tests++;
        if (done_cyc != 3 || ir !== 32'h1234_5678 || pc_plus4 !== 32'h4000) begin
            fails++;
            $display("FAIL range_last_word: done_cycle=%0d ir=%h pc_plus4=%h expected 3 12345678 00004000",
                     done_cyc, ir, pc_plus4);
        end
    endtask

    task automatic test_stall();
        int done_cyc = -1;
        int req_cycles = 0;
        start = 1'b1; pc = 32'h3100;
        step();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
            if (mem_req_valid === 1'b1) req_cycles++;
            mem_req_ready = (c == 4);
            mem_rsp_valid = (c == 7);
            mem_rsp_data  = 32'hCAFE_0007;
            step();
        end
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        tests++;
        if (done_cyc != 8 || req_cycles != 4) begin
            fails++;
            $display("FAIL stall_latency: done_cycle=%0d req_cycles=%0d expected 8 4", done_cyc, req_cycles);
        end
        tests++;
        if (ir !== 32'hCAFE_0007 || pc_plus4 !== 32'h3104) begin
            fails++;
            $display("FAIL stall_data: ir=%h pc_plus4=%h expected cafe0007 00003104", ir, pc_plus4);
        end
    endtask

    task automatic test_timeout();
        int fault_cyc = -1;
        int req_cycles = 0;
        int pcw_seen = 0;
        start = 1'b1; pc = 32'h3200;
        step();
        start = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            if (fault === 1'b1 && fault_cyc < 0) fault_cyc = c;
            if (mem_req_valid === 1'b1) req_cycles++;
            if (pc_write === 1'b1) pcw_seen++;
            step();
        end
        tests++;
        if (fault_cyc != 17 || fault_code !== 2'b11) begin
            fails++;
            $display("FAIL timeout_fault: fault_cycle=%0d code=%b expected 17 11", fault_cyc, fault_code);
        end
        tests++;
        if (req_cycles != 16 || pcw_seen != 0 || ir !== 32'hCAFE_0007) begin
            fails++;
            $display("FAIL timeout_side: req_cycles=%0d pc_write_pulses=%0d ir=%h expected 16 0 cafe0007",
                     req_cycles, pcw_seen, ir);
        end
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
        step(); step();
        mem_rsp_valid = 1'b0;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || ir !== 32'hCAFE_0007) begin
            fails++;
            $display("FAIL timeout_late_rsp: done=%b busy=%b ir=%h expected 0 0 cafe0007", done, busy, ir);
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        start = 1'b1; pc = 32'h3008;
        step();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (done === 1'b1) dones++;
            mem_req_ready = (c == 1);
            start         = (c == 2);
            pc            = (c == 2) ? 32'h3010 : 32'h3008;
            mem_rsp_valid = (c == 3);
            mem_rsp_data  = 32'hAAAA_0001;
            step();
        end
        start = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        tests++;
        if (dones != 1 || ir !== 32'hAAAA_0001 || pc_plus4 !== 32'h300C || mem_addr !== 32'h3008) begin
            fails++;
            $display("FAIL back_to_back: dones=%0d ir=%h pc_plus4=%h addr=%h expected 1 aaaa0001 0000300c 00003008",
                     dones, ir, pc_plus4, mem_addr);
        end
        // A start right after done/fault is accepted
        start = 1'b1; pc = 32'h3020;
        step();
        start = 1'b0;
        tests++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h3020 || pc_plus4 !== 32'h3024) begin
            fails++;
            $display("FAIL next_fetch: req=%b addr=%h pc_plus4=%h expected 1 00003020 00003024",
                     mem_req_valid, mem_addr, pc_plus4);
        end
    endtask

    task automatic test_reset_mid_fetch();
        // Continues the fetch of 0x3020 started above: now in REQ
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++;
        if (busy !== 1'b0 || ir !== 32'h0 || pc_plus4 !== 32'h3000 || mem_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b ir=%h pc_plus4=%h req=%b expected 0 00000000 00003000 0",
                     busy, ir, pc_plus4, mem_req_valid);
        end
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_AAAA;
        step(); step();
        mem_rsp_valid = 1'b0;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || ir !== 32'h0) begin
            fails++;
            $display("FAIL reset_late_rsp: done=%b busy=%b ir=%h expected 0 0 00000000", done, busy, ir);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_misaligned();
        test_range();
        test_stall();
        test_timeout();
        test_back_to_back();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Multi-cycle instruction fetch unit sitting between the program counter register and instruction memory. On a `start` from the main controller it samples the current PC and checks its alignment and range. It then runs a valid/ready read transaction to instruction memory, latches the returned word into the instruction register, and pulses `pc_write` so the PC loads `pc_plus4`. Bad addresses and stalled memory are reported as single-cycle faults instead of hanging the CPU.

## Interface
- `INIT`, 32'h0000_3000, text segment base; also the reset value of `pc_plus4`.
- `TEXT_BYTES`, 32'h0000_1000, text segment size in bytes; legal addresses are INIT .. INIT+TEXT_BYTES-1.
- `TIMEOUT`, 16, maximum total cycles spent in REQ+WAIT before a timeout fault; must be ≥ 2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  fetch request from controller; honoured only in IDLE.
- `pc`  in  32  current PC value, sampled on accepted `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `ir` is valid from this cycle on.
- `pc_write`  out  1  one-cycle pulse, coincident with `done`; PC enable.
- `pc_plus4`  out  32  latched PC + 4, modulo 2^32; next-PC value.
- `ir`  out  32  instruction register.
- `fault`  out  1  one-cycle pulse on a failed fetch.
- `fault_code`  out  2  01 misaligned, 10 out of range, 11 timeout; held until the next fault.
- `mem_req_valid`  out  1  read request valid.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_addr`  out  32  latched PC; stable while `mem_req_valid` is high.
- `mem_rsp_valid`  in  1  read data valid.
- `mem_rsp_data`  in  32  read data.

## Operation
- States: IDLE, REQ, WAIT, DONE, FAULT.
- **IDLE**
  - If `start` is high: latch `pc` into `addr_q`, load `pc_plus4` ← `pc` + 4, clear timeout counter `cnt`.
  - If `pc[1:0]` ≠ 0: go to FAULT, code 01.
  - Else if `pc` is out of range: go to FAULT, code 10.
  - Else: go to REQ.
- **REQ**
  - `mem_req_valid` = 1, `mem_addr` = `addr_q`.
  - If `mem_req_ready`: go to WAIT.
  - `mem_rsp_valid` is ignored in REQ.
- **WAIT**
  - If `mem_rsp_valid`: `ir` ← `mem_rsp_data`, go to DONE.
  - If `mem_rsp_valid` and `mem_req_ready` are high together, only the response counts; no new request is issued.
- **Timeout**
  - `cnt` increments on each REQ/WAIT cycle that does not leave the state.
  - If `cnt` = TIMEOUT-1 and that cycle's exit condition is false: go to FAULT, code 11. Do not request again; drop any later response.
- **DONE**: `done` = 1 and `pc_write` = 1 for exactly one cycle, then go to IDLE.
- **FAULT**: `fault` = 1 for one cycle, then go to IDLE. `ir` and `pc_write` are not touched, so the PC does not advance.
- `start` while `busy` is ignored; no queueing.
- `pc_plus4` wraps: 32'hFFFF_FFFC + 4 = 0. That address is still range-faulted before any memory access.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `done`, `pc_write`, `fault`, `mem_req_valid` = 0.
  - `ir` = 0, `fault_code` = 00, `pc_plus4` = INIT, `mem_addr` = INIT.
- All outputs are registered or decoded from state only; there is no combinational path from memory inputs to outputs.
- Minimum latency: `start` at cycle 0, REQ at cycle 1 (ready high), WAIT at cycle 2 (rsp high), `done`/`pc_write` at cycle 3.
- Each memory wait cycle adds one cycle.
- Fault latency: misaligned or range fault pulses at cycle 1; timeout pulses TIMEOUT+1 cycles after `start`.
- Reset in any state takes effect on the next edge and returns to IDLE. An outstanding request is abandoned; a response arriving later in IDLE is ignored.
- Next fetch: `start` may be asserted in the cycle after `done` or `fault`.

## Test plan
- **Basic fetch**: `pc`=0x3000, ready and rsp each high one cycle after request, data 0x8C010004 → `done`/`pc_write` at cycle 3, `ir`=0x8C010004, `pc_plus4`=0x3004.
- **Misaligned**: `pc`=0x3002 → `fault` at cycle 1, `fault_code`=01, `mem_req_valid` never high, `ir` unchanged, no `pc_write`.
- **Range**: `pc`=0x2FFC, then `pc`=0x4000 → fault code 10 both times. `pc`=0x3FFC → normal fetch, `pc_plus4`=0x4000.
- **Stall/timeout**: ready held low 3 cycles then high, rsp 2 cycles later → `done` at cycle 8. With rsp never arriving and TIMEOUT=16 → `fault`, code 11, at cycle 17.
- **Back-pressure ignore**: assert `start` during WAIT with `pc`=0x3010 → still one `done`; `ir` and `pc_plus4` come from the original fetch.
- **Reset mid-fetch**: reset asserted in WAIT → next cycle IDLE, `ir`=0, `pc_plus4`=0x3000. A late rsp produces no `done`.
